// File: rtl/clk_div_sched_if.sv
// Run-control / configuration / status bundle for clk_div_sched.
// Optional feature macro: CLK_DIV_BURST_EN (adds burst_len / done).
// Signals:
//   start, stop, hold   run control requests (sampled every clock edge)
//   cfg_valid, cfg_sel  rate-select offer; cfg_ready accepts it
//   tick                one-cycle enable per divided period
//   clk_div_out         registered 50% duty divided output
//   busy                high while running or paused
//   tick_cnt            ticks since last start (wrapping)
//   burst_len, done     burst length / end-of-burst pulse (CLK_DIV_BURST_EN)
// Modports: master drives the requests, slave is the scheduler.
interface clk_div_sched_if #(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned TCNT_W = 8
);
  logic              start;
  logic              stop;
  logic              hold;
  logic              cfg_valid;
  logic [SEL_W-1:0]  cfg_sel;
  logic              cfg_ready;
  logic              tick;
  logic              clk_div_out;
  logic              busy;
  logic [TCNT_W-1:0] tick_cnt;
`ifdef CLK_DIV_BURST_EN
  logic [TCNT_W-1:0] burst_len;
  logic              done;

  modport master (
    output start, stop, hold, cfg_valid, cfg_sel, burst_len,
    input  cfg_ready, tick, clk_div_out, busy, tick_cnt, done
  );
  modport slave (
    input  start, stop, hold, cfg_valid, cfg_sel, burst_len,
    output cfg_ready, tick, clk_div_out, busy, tick_cnt, done
  );
`else
  modport master (
    output start, stop, hold, cfg_valid, cfg_sel,
    input  cfg_ready, tick, clk_div_out, busy, tick_cnt
  );
  modport slave (
    input  start, stop, hold, cfg_valid, cfg_sel,
    output cfg_ready, tick, clk_div_out, busy, tick_cnt
  );
`endif
endinterface

// File: rtl/clk_div_sched.sv
// Run-control and rate scheduler for the power-of-two clock divider.
// Owns a gated prescaler a; divide ratio is 2^(sel+1), from /2 to /2^CNT_W.
// Rate changes offered while running are held pending and applied on the
// edge that produces the next tick, so every period is whole.
// Optional feature macro: CLK_DIV_BURST_EN (stop after burst_len ticks).
// Ports:
//   clk_in    system clock, rising edge
//   rst       asynchronous active-high reset
//   sched_if  clk_div_sched_if.slave: control, config handshake, status
module clk_div_sched #(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned TCNT_W = 8
) (
  input logic                 clk_in,
  input logic                 rst,
  clk_div_sched_if.slave      sched_if
);

  localparam int unsigned CNT_W = 2 ** SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    a_q, a_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                pend_q, pend_d;
  logic [SEL_W-1:0]    pend_sel_q, pend_sel_d;
  logic                tick_q, tick_d;
  logic                clk_div_q, clk_div_d;
  logic                busy_q, busy_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;
`ifdef CLK_DIV_BURST_EN
  logic [TCNT_W-1:0]   burst_q, burst_d;
  logic                done_q, done_d;
`endif

  logic                cfg_xfer;
  logic                wrap;
  logic                burst_end;
  logic [CNT_W-1:0]    mask;

  // State and output registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      sel_q       <= '0;
      pend_q      <= 1'b0;
      pend_sel_q  <= '0;
      tick_q      <= 1'b0;
      clk_div_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      tick_cnt_q  <= '0;
`ifdef CLK_DIV_BURST_EN
      burst_q     <= '0;
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      sel_q       <= sel_d;
      pend_q      <= pend_d;
      pend_sel_q  <= pend_sel_d;
      tick_q      <= tick_d;
      clk_div_q   <= clk_div_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
      tick_cnt_q  <= tick_cnt_d;
`ifdef CLK_DIV_BURST_EN
      burst_q     <= burst_d;
      done_q      <= done_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    sel_d       = sel_q;
    pend_d      = pend_q;
    pend_sel_d  = pend_sel_q;
    tick_d      = 1'b0;
    clk_div_d   = clk_div_q;
    busy_d      = busy_q;
    cfg_ready_d = cfg_ready_q;
    tick_cnt_d  = tick_cnt_q;
`ifdef CLK_DIV_BURST_EN
    burst_d     = burst_q;
    done_d      = 1'b0;
`endif

    cfg_xfer = sched_if.cfg_valid && cfg_ready_q;

    // Low sel+1 bits of the prescaler all ones marks the last cycle of a period
    for (int unsigned i = 0; i < CNT_W; i++) begin
      mask[i] = (i <= 32'(sel_q));
    end
    wrap = ((a_q & mask) == mask);

    // tick_q high means the previous edge produced a tick; end burst one edge later
`ifdef CLK_DIV_BURST_EN
    burst_end = tick_q && (burst_q != '0) && (tick_cnt_q == burst_q);
`else
    burst_end = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cfg_xfer) sel_d = sched_if.cfg_sel;
        if (sched_if.start && !sched_if.stop) begin
          state_d    = ST_RUN;
          a_d        = '0;
          tick_cnt_d = '0;
          busy_d     = 1'b1;
`ifdef CLK_DIV_BURST_EN
          burst_d    = sched_if.burst_len;
`endif
        end
      end

      ST_RUN, ST_PAUSE: begin
        if (sched_if.stop || burst_end) begin
          state_d     = ST_IDLE;
          a_d         = '0;
          clk_div_d   = 1'b0;
          busy_d      = 1'b0;
          pend_d      = 1'b0;
          cfg_ready_d = 1'b1;
          // Any rate still in flight lands on entry to IDLE
          if (cfg_xfer)    sel_d = sched_if.cfg_sel;
          else if (pend_q) sel_d = pend_sel_q;
`ifdef CLK_DIV_BURST_EN
          done_d      = burst_end;
`endif
        end else begin
          if (cfg_xfer) begin
            if (state_q == ST_PAUSE) begin
              sel_d = sched_if.cfg_sel;
            end else begin
              pend_sel_d  = sched_if.cfg_sel;
              pend_d      = 1'b1;
              cfg_ready_d = 1'b0;
            end
          end
          if (sched_if.hold) begin
            state_d = ST_PAUSE;
          end else begin
            // The PAUSE->RUN edge counts, so a hold costs exactly its length
            state_d   = ST_RUN;
            a_d       = a_q + CNT_W'(1);
            tick_d    = wrap;
            clk_div_d = a_q[sel_q];
            if (wrap) begin
              tick_cnt_d = tick_cnt_q + TCNT_W'(1);
              if (pend_q) begin
                sel_d       = pend_sel_q;
                a_d         = '0;
                pend_d      = 1'b0;
                cfg_ready_d = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sched_if.cfg_ready   = cfg_ready_q;
  assign sched_if.tick        = tick_q;
  assign sched_if.clk_div_out = clk_div_q;
  assign sched_if.busy        = busy_q;
  assign sched_if.tick_cnt    = tick_cnt_q;
`ifdef CLK_DIV_BURST_EN
  assign sched_if.done        = done_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched with hand-computed expectations.
module tb_clk_div_sched;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  clk_div_sched_if #(.SEL_W(2), .TCNT_W(8)) bus ();

  clk_div_sched #(.SEL_W(2), .TCNT_W(8)) dut (
    .clk_in   (clk),
    .rst      (rst),
    .sched_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit past it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Count edges until tick is seen high; bounded
  task automatic wait_tick(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.tick && n < 200);
    if (!bus.tick) n = -1;
    check(tag, 32'(n), 32'(exp));
  endtask

  task automatic start_run(input logic [1:0] s);
    bus.start     = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = s;
    cyc();
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.hold      = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_sel   = 2'd0;
`ifdef CLK_DIV_BURST_EN
    bus.burst_len = 8'd0;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_tick",      32'(bus.tick),        0);
    check("rst_clkdiv",    32'(bus.clk_div_out), 0);
    check("rst_busy",      32'(bus.busy),        0);
    check("rst_cfg_ready", 32'(bus.cfg_ready),   1);
    check("rst_tick_cnt",  32'(bus.tick_cnt),    0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // /2: ticks at k+2, k+4, k+6; clk_div_out toggles every cycle
    start_run(2'd0);
    check("s0_busy", 32'(bus.busy), 1);
    check("s0_tick_k", 32'(bus.tick), 0);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      check($sformatf("s0_tick_%0d", j),   32'(bus.tick),        32'((j % 2) == 0));
      check($sformatf("s0_clkdiv_%0d", j), 32'(bus.clk_div_out), 32'((j % 2) == 0));
    end
    check("s0_tick_cnt", 32'(bus.tick_cnt), 3);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check("s0_stop_busy",   32'(bus.busy),        0);
    check("s0_stop_clkdiv", 32'(bus.clk_div_out), 0);
    check("s0_stop_cnt",    32'(bus.tick_cnt),    3);

    // /4 running, /16 offered mid-period; applied at the next tick
    start_run(2'd1);
    wait_tick("s1_lat", 4);
    wait_tick("s1_per", 4);
    cyc();
    check("cfg_ready_pre", 32'(bus.cfg_ready), 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = 2'd3;
    cyc();
    bus.cfg_valid = 1'b0;
    check("cfg_ready_pend", 32'(bus.cfg_ready), 0);
    wait_tick("cfg_old_rate", 2);
    check("cfg_ready_back", 32'(bus.cfg_ready), 1);
    wait_tick("cfg_new_per0", 16);
    wait_tick("cfg_new_per1", 16);
    check("cfg_tick_cnt", 32'(bus.tick_cnt), 5);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;

    // /8 with a 5-cycle hold in the middle of a period: spacing 13
    start_run(2'd2);
    wait_tick("s2_lat", 8);
    wait_tick("s2_per", 8);
    cyc();
    cyc();
    bus.hold = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cyc();
      check($sformatf("hold_cnt_%0d", j),  32'(bus.tick_cnt), 2);
      check($sformatf("hold_tick_%0d", j), 32'(bus.tick),     0);
    end
    check("hold_busy", 32'(bus.busy), 1);
    bus.hold = 1'b0;
    wait_tick("hold_resume", 6);
    check("hold_cnt_after", 32'(bus.tick_cnt), 3);

    // Pause right after a tick (clk_div_out high), then stop from PAUSE
    bus.hold = 1'b1;
    cyc();
    check("pause_clkdiv", 32'(bus.clk_div_out), 1);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    bus.hold = 1'b0;
    check("pstop_clkdiv", 32'(bus.clk_div_out), 0);
    check("pstop_busy",   32'(bus.busy),        0);
    check("pstop_cnt",    32'(bus.tick_cnt),    3);

    // start and stop on the same edge in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_busy", 32'(bus.busy), 0);
    cyc();
    cyc();
    check("ss_busy_later", 32'(bus.busy), 0);
    check("ss_tick",       32'(bus.tick), 0);

    // Reset mid-run at /16 with the prescaler at 5
    start_run(2'd3);
    wait_tick("s3_lat", 16);
    repeat (5) cyc();
    check("mid_busy", 32'(bus.busy),     1);
    check("mid_cnt",  32'(bus.tick_cnt), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   32'(bus.busy),        0);
    check("arst_cnt",    32'(bus.tick_cnt),    0);
    check("arst_ready",  32'(bus.cfg_ready),   1);
    check("arst_tick",   32'(bus.tick),        0);
    check("arst_clkdiv", 32'(bus.clk_div_out), 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    start_run(2'd3);
    wait_tick("arst_relat", 16);

    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;

`ifdef CLK_DIV_BURST_EN
    // Burst of 3 ticks at /2: done one edge after the third tick
    bus.burst_len = 8'd3;
    start_run(2'd0);
    bus.burst_len = 8'd0;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      check($sformatf("b_tick_%0d", j), 32'(bus.tick), 32'((j % 2) == 0));
      check($sformatf("b_done_%0d", j), 32'(bus.done), 0);
    end
    cyc();
    check("b_done",  32'(bus.done),     1);
    check("b_busy",  32'(bus.busy),     0);
    check("b_cnt",   32'(bus.tick_cnt), 3);
    cyc();
    check("b_done_clr", 32'(bus.done), 0);
    check("b_idle_tick", 32'(bus.tick), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
